// File: rtl/el2_dec_halt_arb_if.sv
// Halt/run handshake bundle between the three requesters (DM, MPC, PMU),
// the TLU status/request lines and the halt arbiter.
interface el2_dec_halt_arb_if;
    // Requester side
    logic       dbg_halt_req;
    logic       dbg_resume_req;
    logic       mpc_halt_req;
    logic       mpc_run_req;
    logic       pmu_halt_req;
    logic       pmu_run_req;
    // TLU side
    logic       core_halted;
    logic       halt_req_o;
    logic       run_req_o;
    // Completion acks, one-cycle pulses
    logic       dbg_halt_ack;
    logic       mpc_halt_ack;
    logic       pmu_halt_ack;
    logic       dbg_resume_ack;
    logic       mpc_run_ack;
    logic       pmu_run_ack;
    // Status
    logic [1:0] owner;
    logic [1:0] arb_state;
    logic       halt_timeout;

    // Arbiter view
    modport slave (
        input  dbg_halt_req, dbg_resume_req, mpc_halt_req, mpc_run_req,
               pmu_halt_req, pmu_run_req, core_halted,
        output halt_req_o, run_req_o,
               dbg_halt_ack, mpc_halt_ack, pmu_halt_ack,
               dbg_resume_ack, mpc_run_ack, pmu_run_ack,
               owner, arb_state, halt_timeout
    );

    // Requester / TLU-model view
    modport master (
        output dbg_halt_req, dbg_resume_req, mpc_halt_req, mpc_run_req,
               pmu_halt_req, pmu_run_req, core_halted,
        input  halt_req_o, run_req_o,
               dbg_halt_ack, mpc_halt_ack, pmu_halt_ack,
               dbg_resume_ack, mpc_run_ack, pmu_run_ack,
               owner, arb_state, halt_timeout
    );
endinterface

// File: rtl/el2_dec_halt_arb.sv
// Halt/run arbiter: merges DM, MPC and PMU halt/run requests into one
// halt/run request pair toward the TLU, tracks the halt owner, routes
// acks back to the owner only, and flags halt latency overruns.
// Internal source index: 0 = DBG, 1 = MPC, 2 = PMU. Owner code = index + 1.
module el2_dec_halt_arb #(
    parameter int unsigned TO_W         = 8,
    // Must be below 2**TO_W so the match value is reachable
    parameter int unsigned HALT_TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst_l,
    el2_dec_halt_arb_if.slave   io_arb
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StHaltPend = 2'd1,
        StHalted   = 2'd2,
        StRunPend  = 2'd3
    } state_e;

    localparam logic [TO_W-1:0] LP_TO_MATCH = TO_W'(HALT_TIMEOUT - 1);

    // Owner code to one-hot source vector
    function automatic logic [2:0] f_onehot(input logic [1:0] own);
        logic [2:0] oh;
        oh = 3'b000;
        case (own)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    state_e            r_state;
    logic [1:0]        r_owner;
    logic [TO_W-1:0]   r_cnt;
    logic              r_halt_req;
    logic              r_run_req;
    logic              r_timeout;
    logic [2:0]        r_halt_ack;
    logic [2:0]        r_run_ack;
    logic [2:0]        r_halt_arm;
    logic [2:0]        r_run_arm;

    logic [2:0]        w_halt_req;
    logic [2:0]        w_run_req;
    logic [2:0]        w_halt_v;
    logic [2:0]        w_run_v;
    logic [1:0]        w_hp_owner;
    logic              w_escalate;
    logic              w_owner_run;
    logic [2:0]        w_halt_ack_set;
    logic [2:0]        w_run_ack_set;

    assign w_halt_req = {io_arb.pmu_halt_req, io_arb.mpc_halt_req, io_arb.dbg_halt_req};
    assign w_run_req  = {io_arb.pmu_run_req,  io_arb.mpc_run_req,  io_arb.dbg_resume_req};
    assign w_halt_v   = w_halt_req & r_halt_arm;
    assign w_run_v    = w_run_req  & r_run_arm;

    // Highest-priority armed halt requester (0 when none)
    always_comb begin
        w_hp_owner = 2'd0;
        if (w_halt_v[0]) begin
            w_hp_owner = 2'd1;
        end else if (w_halt_v[1]) begin
            w_hp_owner = 2'd2;
        end else if (w_halt_v[2]) begin
            w_hp_owner = 2'd3;
        end
    end

    // Lower owner code means higher priority; owner 0 never escalates
    assign w_escalate = (w_hp_owner != 2'd0) && (w_hp_owner < r_owner);

    // Armed run request from the current owner
    always_comb begin
        w_owner_run = 1'b0;
        case (r_owner)
            2'd1:    w_owner_run = w_run_v[0];
            2'd2:    w_owner_run = w_run_v[1];
            2'd3:    w_owner_run = w_run_v[2];
            default: w_owner_run = 1'b0;
        endcase
    end

    // Which ack fires at the next edge; shared by FSM and arm-bit logic
    always_comb begin
        w_halt_ack_set = 3'b000;
        w_run_ack_set  = 3'b000;
        unique case (r_state)
            StHaltPend: begin
                // Ack goes to the final owner, including a same-cycle escalation
                if (io_arb.core_halted) begin
                    w_halt_ack_set = f_onehot(w_escalate ? w_hp_owner : r_owner);
                end
            end
            StHalted: begin
                if (w_escalate) begin
                    w_halt_ack_set = f_onehot(w_hp_owner);
                end
            end
            StRunPend: begin
                if (!io_arb.core_halted) begin
                    w_run_ack_set = f_onehot(r_owner);
                end
            end
            default: begin
            end
        endcase
    end

    // Arbitration FSM with registered request, ack and timeout outputs
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state    <= StRun;
            r_owner    <= 2'd0;
            r_cnt      <= '0;
            r_halt_req <= 1'b0;
            r_run_req  <= 1'b0;
            r_timeout  <= 1'b0;
            r_halt_ack <= 3'b000;
            r_run_ack  <= 3'b000;
        end else begin
            r_halt_ack <= w_halt_ack_set;
            r_run_ack  <= w_run_ack_set;
            r_timeout  <= 1'b0;
            unique case (r_state)
                StRun: begin
                    // Run requests are meaningless while running
                    if (w_hp_owner != 2'd0) begin
                        r_owner    <= w_hp_owner;
                        r_halt_req <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= StHaltPend;
                    end
                end
                StHaltPend: begin
                    if (r_cnt != {TO_W{1'b1}}) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                    if (w_escalate) begin
                        r_owner <= w_hp_owner;
                    end
                    if (io_arb.core_halted) begin
                        r_halt_req <= 1'b0;
                        r_state    <= StHalted;
                    end else if (r_cnt == LP_TO_MATCH) begin
                        // Counter saturates past the match, so this fires once
                        r_timeout <= 1'b1;
                    end
                end
                StHalted: begin
                    // A higher-priority halt takes ownership before any resume
                    if (w_escalate) begin
                        r_owner <= w_hp_owner;
                    end else if (w_owner_run) begin
                        r_run_req <= 1'b1;
                        r_state   <= StRunPend;
                    end
                end
                StRunPend: begin
                    if (!io_arb.core_halted) begin
                        r_run_req <= 1'b0;
                        r_owner   <= 2'd0;
                        r_state   <= StRun;
                    end
                end
            endcase
        end
    end

    // Arm bits: drop with the ack, re-arm once the request is seen low
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_halt_arm <= 3'b111;
            r_run_arm  <= 3'b111;
        end else begin
            r_halt_arm <= (r_halt_arm | ~w_halt_req) & ~w_halt_ack_set;
            r_run_arm  <= (r_run_arm  | ~w_run_req)  & ~w_run_ack_set;
        end
    end

    assign io_arb.halt_req_o     = r_halt_req;
    assign io_arb.run_req_o      = r_run_req;
    assign io_arb.dbg_halt_ack   = r_halt_ack[0];
    assign io_arb.mpc_halt_ack   = r_halt_ack[1];
    assign io_arb.pmu_halt_ack   = r_halt_ack[2];
    assign io_arb.dbg_resume_ack = r_run_ack[0];
    assign io_arb.mpc_run_ack    = r_run_ack[1];
    assign io_arb.pmu_run_ack    = r_run_ack[2];
    assign io_arb.owner          = r_owner;
    assign io_arb.arb_state      = r_state;
    assign io_arb.halt_timeout   = r_timeout;

endmodule
